// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the MIPS writeback path.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Circular buffer of pending load returns; also exposes which registers have
// a queued write so the top can build the pending mask.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  wb_entry_t           push_entry_i,
    input  logic                pop_i,
    output wb_entry_t           head_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                empty_o,
    output logic [NUM_REGS-1:0] dest_vec_o
);

    wb_entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Push and pop never target the same slot: that needs empty or full.
            if (push_i) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    always_comb begin
        dest_vec_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                dest_vec_o[mem_q[i].dest] = 1'b1;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU results and buffered load returns onto the register-file write port.
// Define WB_LOAD_BYPASS_EN to let a load skip the empty FIFO when the port is free.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int DEPTH        = 4,
    parameter  int STARVE_LIMIT = 8,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_dest,
    input  logic [REG_DATA_W-1:0] alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_dest,
    input  logic [REG_DATA_W-1:0] ld_data,
    output logic                  reg_write_en,
    output logic [REG_ADDR_W-1:0] reg_write_dest,
    output logic [REG_DATA_W-1:0] reg_write_data,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic [CNT_W-1:0]      fifo_count,
    output logic                  alu_hold
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic                  wen_q,  wen_d;
    logic [REG_ADDR_W-1:0] wdest_q, wdest_d;
    logic [REG_DATA_W-1:0] wdata_q, wdata_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic                  hold_q, hold_d;

    logic                  alu_win, ld_live, ld_bypass, push, pop, fifo_empty;
    wb_entry_t             head, push_entry;
    logic [NUM_REGS-1:0]   fifo_dest_vec;

    assign ld_ready = (fifo_count < CNT_W'(DEPTH));
    assign alu_win  = alu_valid && (alu_dest != REG_ZERO);
    assign ld_live  = ld_valid && ld_ready && (ld_dest != REG_ZERO);

`ifdef WB_LOAD_BYPASS_EN
    assign ld_bypass = ld_live && fifo_empty && !alu_win;
`else
    assign ld_bypass = 1'b0;
`endif

    assign push = ld_live && !ld_bypass;
    assign pop  = !alu_win && !fifo_empty;
    assign push_entry = '{dest: ld_dest, data: ld_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (fifo_count),
        .empty_o      (fifo_empty),
        .dest_vec_o   (fifo_dest_vec)
    );

    always_comb begin
        wen_d   = 1'b0;
        wdest_d = wdest_q;
        wdata_d = wdata_q;
        if (alu_win) begin
            wen_d   = 1'b1;
            wdest_d = alu_dest;
            wdata_d = alu_data;
        end else if (pop) begin
            wen_d   = 1'b1;
            wdest_d = head.dest;
            wdata_d = head.data;
        end else if (ld_bypass) begin
            wen_d   = 1'b1;
            wdest_d = ld_dest;
            wdata_d = ld_data;
        end
    end

    // Counts only cycles where the queue had work and the ALU took the port.
    always_comb begin
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (alu_win && (starve_q != STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end else begin
            starve_d = starve_q;
        end

        if (pop) begin
            hold_d = 1'b0;
        end else if (starve_d == STV_W'(STARVE_LIMIT)) begin
            hold_d = 1'b1;
        end else begin
            hold_d = hold_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q    <= 1'b0;
            wdest_q  <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            wen_q    <= wen_d;
            wdest_q  <= wdest_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

    assign reg_write_en   = wen_q;
    assign reg_write_dest = wdest_q;
    assign reg_write_data = wdata_q;
    assign alu_hold       = hold_q;

    assign pending_mask[0] = 1'b0;
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_mask
        assign pending_mask[gi] = fifo_dest_vec[gi] |
                                  (wen_q && (wdest_q == REG_ADDR_W'(gi)));
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed checks of the writeback arbiter: latency, priority, starvation, reset.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_dest;
    logic [31:0] ld_data;
    logic        reg_write_en;
    logic [4:0]  reg_write_dest;
    logic [31:0] reg_write_data;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;
    logic        alu_hold;

    int n_vec  = 0;
    int n_fail = 0;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_dest       (alu_dest),
        .alu_data       (alu_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_dest        (ld_dest),
        .ld_data        (ld_data),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .pending_mask   (pending_mask),
        .fifo_count     (fifo_count),
        .alu_hold       (alu_hold)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic [4:0] d, input logic [31:0] v);
        check({tag, ".en"},   {31'd0, reg_write_en}, 32'd1);
        check({tag, ".dest"}, {27'd0, reg_write_dest}, {27'd0, d});
        check({tag, ".data"}, reg_write_data, v);
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_dest = 5'd0; alu_data = 32'd0;
        ld_valid  = 1'b0; ld_dest  = 5'd0; ld_data  = 32'd0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        check("rst.en",    {31'd0, reg_write_en}, 32'd0);
        check("rst.dest",  {27'd0, reg_write_dest}, 32'd0);
        check("rst.data",  reg_write_data, 32'd0);
        check("rst.count", {29'd0, fifo_count}, 32'd0);
        check("rst.hold",  {31'd0, alu_hold}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst.ready", {31'd0, ld_ready}, 32'd1);
        check("rst.mask",  pending_mask, 32'd0);

        // Single load, ALU idle.
        ld_valid = 1'b1; ld_dest = 5'd5; ld_data = 32'hDEADBEEF;
        tick();
        idle();
`ifdef WB_LOAD_BYPASS_EN
        check_wr("ld1.p1", 5'd5, 32'hDEADBEEF);
        check("ld1.p1.mask", pending_mask, 32'h20);
        tick();
        check("ld1.p2.en", {31'd0, reg_write_en}, 32'd0);
`else
        check("ld1.p1.en",    {31'd0, reg_write_en}, 32'd0);
        check("ld1.p1.count", {29'd0, fifo_count}, 32'd1);
        check("ld1.p1.mask",  pending_mask, 32'h20);
        tick();
        check_wr("ld1.p2", 5'd5, 32'hDEADBEEF);
        check("ld1.p2.mask",  pending_mask, 32'h20);
        check("ld1.p2.count", {29'd0, fifo_count}, 32'd0);
        tick();
        check("ld1.p3.en",   {31'd0, reg_write_en}, 32'd0);
        check("ld1.p3.dest", {27'd0, reg_write_dest}, 32'd5);
        check("ld1.p3.mask", pending_mask, 32'd0);
`endif

        // ALU and load in the same cycle: ALU first, load next.
        alu_valid = 1'b1; alu_dest = 5'd3; alu_data = 32'h11;
        ld_valid  = 1'b1; ld_dest  = 5'd4; ld_data  = 32'h22;
        tick();
        idle();
        check_wr("same.n1", 5'd3, 32'h11);
        check("same.n1.mask", pending_mask, 32'h18);
        tick();
        check_wr("same.n2", 5'd4, 32'h22);
        check("same.n2.mask", pending_mask, 32'h10);
        tick();
        check("same.n3.en", {31'd0, reg_write_en}, 32'd0);

        // ALU every cycle while loads 20..24 are offered.
        for (int i = 0; i < 9; i++) begin
            int li;
            li = (i < 4) ? i : 4;
            alu_valid = 1'b1; alu_dest = 5'(8 + i); alu_data = 32'hA0 + 32'(i);
            ld_valid  = 1'b1; ld_dest  = 5'(20 + li); ld_data = 32'h100 + 32'(li);
            check($sformatf("stv%0d.ready", i), {31'd0, ld_ready}, (i < 4) ? 32'd1 : 32'd0);
            tick();
            check_wr($sformatf("stv%0d", i), 5'(8 + i), 32'hA0 + 32'(i));
            check($sformatf("stv%0d.hold", i), {31'd0, alu_hold}, (i == 8) ? 32'd1 : 32'd0);
        end
        check("stv.count", {29'd0, fifo_count}, 32'd4);

        // Drain: first pop happens with the FIFO full and a load still offered.
        alu_valid = 1'b0;
        check("drn.full.ready", {31'd0, ld_ready}, 32'd0);
        tick();
        check_wr("drn1", 5'd20, 32'h100);
        check("drn1.count", {29'd0, fifo_count}, 32'd3);
        check("drn1.hold",  {31'd0, alu_hold}, 32'd0);
        check("drn1.ready", {31'd0, ld_ready}, 32'd1);
        tick();
        idle();
        check_wr("drn2", 5'd21, 32'h101);
        check("drn2.count", {29'd0, fifo_count}, 32'd3);
        check("drn2.mask",  pending_mask, 32'h01E0_0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_wr($sformatf("drn%0d", k + 3), 5'(22 + k), 32'h102 + 32'(k));
            check($sformatf("drn%0d.count", k + 3), {29'd0, fifo_count}, 32'(2 - k));
        end
        tick();
        check("drn.end.en", {31'd0, reg_write_en}, 32'd0);

        // ALU to r0 yields the slot to a queued load.
        ld_valid = 1'b1; ld_dest = 5'd7; ld_data = 32'h77;
        tick();
        idle();
`ifndef WB_LOAD_BYPASS_EN
        check("r0.q.count", {29'd0, fifo_count}, 32'd1);
        check("r0.q.mask",  pending_mask, 32'h80);
        alu_valid = 1'b1; alu_dest = 5'd0; alu_data = 32'h55;
        tick();
        idle();
`endif
        check_wr("r0.ld", 5'd7, 32'h77);
        check("r0.mask", pending_mask, 32'h80);
        check("r0.count", {29'd0, fifo_count}, 32'd0);
        ld_valid = 1'b1; ld_dest = 5'd0; ld_data = 32'h99;
        tick();
        idle();
        check("r0.drop.count", {29'd0, fifo_count}, 32'd0);
        check("r0.drop.en",    {31'd0, reg_write_en}, 32'd0);
        check("r0.drop.mask",  pending_mask, 32'd0);

        // Mid-operation reset with three queued loads and a live write.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_dest = 5'd1; alu_data = 32'(i);
            ld_valid  = 1'b1; ld_dest  = 5'(12 + i); ld_data = 32'h300 + 32'(i);
            tick();
        end
        check("mr.pre.count", {29'd0, fifo_count}, 32'd3);
        check("mr.pre.en",    {31'd0, reg_write_en}, 32'd1);
        rst = 1'b1;
        #1;
        idle();
        check("mr.en",    {31'd0, reg_write_en}, 32'd0);
        check("mr.count", {29'd0, fifo_count}, 32'd0);
        check("mr.mask",  pending_mask, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mr.post%0d.en", i), {31'd0, reg_write_en}, 32'd0);
        end
        check("mr.post.count", {29'd0, fifo_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-side initiator for the 32x32 MIPS register file. It merges single-cycle ALU results with variable-latency load returns onto the register file's single write port (write enable, destination, data). Load returns are buffered in a small FIFO. A pending-write mask feeds the hazard/stall logic, and a starvation counter requests ALU hold-off.

Parameters:
DEPTH, 4, load-return FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose arbitration before alu_hold asserts

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU result present this cycle; no backpressure
alu_dest  in  5  ALU destination register
alu_data  in  32  ALU result
ld_valid  in  1  load return offered
ld_ready  out  1  load return accepted when ld_valid && ld_ready
ld_dest  in  5  load destination register
ld_data  in  32  load data
reg_write_en  out  1  register file write enable
reg_write_dest  out  5  register file write address
reg_write_data  out  32  register file write data
pending_mask  out  32  bit d=1: write to register d outstanding (queued or on write port)
fifo_count  out  $clog2(DEPTH+1)  occupied FIFO entries
alu_hold  out  1  request upstream to suppress ALU writeback next cycle

Behaviour:
- Reset (async, rst=1): FIFO empty, fifo_count=0, reg_write_en=0, reg_write_dest=0, reg_write_data=0, alu_hold=0, starve counter=0. ld_ready=1 and pending_mask=0 once rst is released.
- The write port is registered. Values selected in cycle N appear on reg_write_* in cycle N+1 and are committed by the register file at the end of N+1.
- Arbitration per cycle, in priority order:
  - alu_valid && alu_dest!=0: ALU result goes to the write port.
  - Else, FIFO non-empty: pop the head to the write port.
  - Else: reg_write_en<=0.
- When reg_write_en=0, reg_write_dest and reg_write_data hold their last values.
- alu_valid with alu_dest=0 is discarded. It does not consume the slot, so the FIFO may drain that cycle.
- ld_ready = (fifo_count < DEPTH), combinational from registered count. A full FIFO refuses pushes even if a pop occurs in the same cycle.
- An accepted load with ld_dest=0 is dropped and not pushed.
- Simultaneous push and pop: fifo_count is unchanged. The pushed entry is never the one popped that cycle unless the FIFO was empty; an empty FIFO never pops (bypass only with the optional feature).
- Load returns drain in strict FIFO order. ALU results are never reordered relative to each other.
- WAW ordering between ALU results and queued loads to the same register is not resolved here; the hazard unit stalls issue using pending_mask.
- pending_mask[d] = OR over valid FIFO entries with dest d, OR (reg_write_en && reg_write_dest==d). Bit 0 is always 0. Combinational from registered state.
- Starve counter:
  - Increments when the FIFO is non-empty and the ALU wins arbitration.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- alu_hold is a registered output. It is set when the counter reaches STARVE_LIMIT and cleared the cycle after the next pop.
- If alu_valid arrives while alu_hold=1, the ALU still wins. alu_hold is advisory only.
- Pointers wrap modulo DEPTH.
- Asserting rst mid-operation discards all queued entries with no write; any in-flight reg_write_en drops immediately.

Optional Feature:
Macro WB_LOAD_BYPASS_EN.
- Defined: if the FIFO is empty, ALU does not win, and a load is accepted with ld_dest!=0, that load goes straight to the write port (write in N+1) and is not pushed.
- Undefined: every accepted load is pushed. Minimum load-to-write latency is 2 cycles (push in N, pop in N+1, write port in N+2).

Decomposition:
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, REG_ZERO=5'd0.
  - wb_entry_t struct {dest[4:0], data[31:0]}.
- One sub-module, wb_fifo: DEPTH-entry circular buffer of wb_entry_t with push/pop, count, and a valid-entry dest vector for building the mask.
- The arbiter, starve counter and mask OR-tree live in the top module.

Test Plan:
- Reset, then ld_valid dest=5 data=0xDEADBEEF with ALU idle:
  - Bypass off: reg_write_en at cycle +2, dest 5, data 0xDEADBEEF; pending_mask[5]=1 from cycle +1 through +2.
  - Bypass on: write at cycle +1.
- Same cycle, alu dest=3 data=0x11 and ld dest=4 data=0x22 -> write (3,0x11) at N+1, write (4,0x22) at N+2.
- ALU valid every cycle and 5 loads offered -> ld_ready=0 after 4 accepts, fifo_count=4; alu_hold=1 after 8 losing cycles. Dropping alu_valid then drains loads in order, and alu_hold clears after the first pop.
- alu dest=0 plus queued load dest=7 -> load written the next cycle; register 0 is never written, pending_mask[0]=0 throughout.
- Full FIFO with simultaneous pop and ld_valid -> ld_ready=0, no push, fifo_count 4->3.
- Assert rst with 3 entries queued and reg_write_en=1 -> reg_write_en=0 immediately, fifo_count=0, pending_mask=0, no write after release.
